// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pkg : shared RV32I load/store encodings and MEM-stage FSM states |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_if : data-memory req/gnt/rvalid bus                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_align : byte-lane steering, load extension and legality check    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsu_align
    import rv32_pkg::*;
(
    input  wire logic [2:0]  funct3,
    input  wire logic [1:0]  addr_lo,
    input  wire logic        is_store,
    input  wire logic [31:0] rs2,
    input  wire logic [31:0] rdata,
    output logic [3:0]       be,
    output logic [31:0]      wdata,
    output logic [31:0]      load_data,
    output logic             illegal
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(rdata >> {addr_lo, 3'b000});
    assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = 4'b0000;
        wdata     = rs2;
        load_data = 32'h0;
        illegal   = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{rs2[7:0]}};
                load_data = (funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
                illegal   = is_store && (funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{rs2[15:0]}};
                load_data = (funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
                illegal   = addr_lo[0] || (is_store && (funct3 == F3_HU));
            end
            F3_W: begin
                be        = 4'hF;
                load_data = rdata;
                illegal   = |addr_lo;
            end
            // funct3 3/6/7 are reserved for both loads and stores
            default: illegal = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage : RV32I MEM-stage load/store unit with MEM/WB register     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_stage
    import rv32_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [31:0] alu_MEM,
    input  wire logic [31:0] rs2_mem_data_MEM,
    input  wire logic [2:0]  funct3_MEM,
    input  wire logic        MemRead_MEM,
    input  wire logic        MemWrite_MEM,
    input  wire logic        RegWrite_MEM,
    input  wire logic        MemtoReg_MEM,
    input  wire logic [4:0]  rd_MEM,
    mem_stage_if.master      dmem,
    output logic             stall_MEM,
    output logic [31:0]      alu_WB,
    output logic [31:0]      load_data_WB,
    output logic             RegWrite_WB,
    output logic             MemtoReg_WB,
    output logic [4:0]       rd_WB,
    output logic             misalign_err_WB
);
    state_t      r_state, w_state_nxt;
    logic        w_is_store, w_access, w_bad, w_illegal, w_legal;
    logic [31:0] w_load_data;
    logic [31:0] r_alu, r_ld;
    logic        r_rw, r_m2r, r_err;
    logic [4:0]  r_rd;

    assign w_is_store = MemWrite_MEM & ~MemRead_MEM;
    assign w_access   = MemRead_MEM | MemWrite_MEM;
    assign w_illegal  = w_access & w_bad;
    assign w_legal    = w_access & ~w_bad;

    lsu_align u_align (
        .funct3    (funct3_MEM),
        .addr_lo   (alu_MEM[1:0]),
        .is_store  (w_is_store),
        .rs2       (rs2_mem_data_MEM),
        .rdata     (dmem.rdata),
        .be        (dmem.be),
        .wdata     (dmem.wdata),
        .load_data (w_load_data),
        .illegal   (w_bad)
    );

    assign dmem.we   = w_is_store;
    assign dmem.addr = {alu_MEM[31:2], 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        dmem.req    = 1'b0;
        stall_MEM   = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (w_legal) begin
                        dmem.req = 1'b1;
                        if (w_is_store) begin
                            stall_MEM = ~dmem.gnt;
                        end else begin
                            stall_MEM = 1'b1;
                            if (dmem.gnt) w_state_nxt = S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    stall_MEM = ~dmem.rvalid;
                    if (dmem.rvalid) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_alu   <= 32'h0;
            r_ld    <= 32'h0;
            r_rw    <= 1'b0;
            r_m2r   <= 1'b0;
            r_rd    <= 5'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (stall_MEM) begin
                r_alu <= 32'h0;
                r_ld  <= 32'h0;
                r_rw  <= 1'b0;
                r_m2r <= 1'b0;
                r_rd  <= 5'd0;
                r_err <= 1'b0;
            end else begin
                // an unstalled cycle in RESP is exactly the rvalid cycle of a load
                r_alu <= alu_MEM;
                r_ld  <= (r_state == S_RESP) ? w_load_data : 32'h0;
                r_rw  <= RegWrite_MEM & ~w_illegal;
                r_m2r <= MemtoReg_MEM;
                r_rd  <= rd_MEM;
                r_err <= w_illegal;
            end
        end
    end

    assign alu_WB          = r_alu;
    assign load_data_WB    = r_ld;
    assign RegWrite_WB     = r_rw;
    assign MemtoReg_WB     = r_m2r;
    assign rd_WB           = r_rd;
    assign misalign_err_WB = r_err;
endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_stage : scoreboard bench for mem_stage                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_MEM, rs2_mem_data_MEM;
    logic [2:0]  funct3_MEM;
    logic        MemRead_MEM, MemWrite_MEM, RegWrite_MEM, MemtoReg_MEM;
    logic [4:0]  rd_MEM;
    logic        stall_MEM;
    logic [31:0] alu_WB, load_data_WB;
    logic        RegWrite_WB, MemtoReg_WB, misalign_err_WB;
    logic [4:0]  rd_WB;

    mem_stage_if dmem ();

    mem_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alu_MEM          (alu_MEM),
        .rs2_mem_data_MEM (rs2_mem_data_MEM),
        .funct3_MEM       (funct3_MEM),
        .MemRead_MEM      (MemRead_MEM),
        .MemWrite_MEM     (MemWrite_MEM),
        .RegWrite_MEM     (RegWrite_MEM),
        .MemtoReg_MEM     (MemtoReg_MEM),
        .rd_MEM           (rd_MEM),
        .dmem             (dmem),
        .stall_MEM        (stall_MEM),
        .alu_WB           (alu_WB),
        .load_data_WB     (load_data_WB),
        .RegWrite_WB      (RegWrite_WB),
        .MemtoReg_WB      (MemtoReg_WB),
        .rd_WB            (rd_WB),
        .misalign_err_WB  (misalign_err_WB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] ld;
        logic        rw;
        logic        m2r;
        logic        err;
        logic [4:0]  rd;
    } wb_t;

    wb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour built lane by lane from the access size
    function automatic void model(input logic [2:0] f3, input logic mr, input logic mw,
                                  input logic [31:0] a, input logic [31:0] rs2,
                                  input logic [31:0] rdata, output logic ill,
                                  output logic [3:0] be, output logic [31:0] wd,
                                  output logic [31:0] ld);
        int nb, off;
        logic rsv, mis;
        nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        rsv = mr ? (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (f3 >= 3'd3);
        mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
        ill = (mr | mw) && (rsv || mis);
        off = int'(a[1:0]) & ~(nb - 1);
        be  = 4'b0;
        wd  = 32'h0;
        ld  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) be[i] = 1'b1;
            wd[8*i +: 8] = rs2[8*(i % nb) +: 8];
        end
        for (int k = 0; k < nb; k++) ld[8*k +: 8] = rdata[8*(off+k) +: 8];
        if (!f3[2] && nb < 4 && ld[8*nb-1])
            for (int k = 8*nb; k < 32; k++) ld[k] = 1'b1;
    endfunction

    // Drives one instruction starting just after a rising edge and runs it to completion
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic [4:0] rd, input int gdly, input int rvdly,
                         input logic [31:0] rdata);
        logic        ill, legal, exp_req, exp_stall, done, in_resp;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld;
        wb_t         e, g;
        int          gnt_at;
        alu_MEM = a; rs2_mem_data_MEM = d; funct3_MEM = f3;
        MemRead_MEM = mr; MemWrite_MEM = mw; RegWrite_MEM = rw; MemtoReg_MEM = m2r; rd_MEM = rd;
        dmem.rdata = rdata;
        model(f3, mr, mw, a, d, rdata, ill, ebe, ewd, eld);
        legal = (mr | mw) && !ill;
        e.alu = a; e.ld = (legal && mr) ? eld : 32'h0;
        e.rw = rw && !ill; e.m2r = m2r; e.rd = rd; e.err = ill;
        sb_q.push_back(e);
        done = 1'b0; in_resp = 1'b0; gnt_at = -1;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem.gnt    = legal && !in_resp && (c == gdly);
            dmem.rvalid = in_resp && (c == gnt_at + rvdly);
            @(negedge clk);
            exp_req   = legal && !in_resp;
            exp_stall = legal && (in_resp ? !dmem.rvalid : (mr || !dmem.gnt));
            check("req", dmem.req, exp_req);
            check("stall", stall_MEM, exp_stall);
            if (exp_req) begin
                check("addr", dmem.addr, {a[31:2], 2'b00});
                check("be", dmem.be, ebe);
                check("we", dmem.we, mw && !mr);
                if (mw) check("wdata", dmem.wdata, ewd);
            end
            if (!in_resp && dmem.gnt && mr) begin
                in_resp = 1'b1;
                gnt_at  = c;
            end
            done = !exp_stall;
            @(posedge clk); #1;
            dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    g = sb_q.pop_front();
                    check("alu_WB", alu_WB, g.alu);
                    check("load_data_WB", load_data_WB, g.ld);
                    check("RegWrite_WB", RegWrite_WB, g.rw);
                    check("MemtoReg_WB", MemtoReg_WB, g.m2r);
                    check("rd_WB", rd_WB, g.rd);
                    check("misalign_err_WB", misalign_err_WB, g.err);
                end
            end else begin
                check("bubble_rw", RegWrite_WB, 0);
                check("bubble_rd", rd_WB, 0);
                check("bubble_ld", load_data_WB, 0);
                check("bubble_err", misalign_err_WB, 0);
            end
        end
        if (!done) check("timeout", 1, 0);
    endtask

    task automatic nop_ctrl();
        MemRead_MEM = 0; MemWrite_MEM = 0; RegWrite_MEM = 0; MemtoReg_MEM = 0;
        rd_MEM = 0; alu_MEM = 0; rs2_mem_data_MEM = 0; funct3_MEM = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        nop_ctrl();
        dmem.gnt = 0; dmem.rvalid = 0; dmem.rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_WB", alu_WB, 0);
        check("rst_RegWrite_WB", RegWrite_WB, 0);
        check("rst_err", misalign_err_WB, 0);
        rst_n = 1'b1;

        // SB lane 3, same-cycle grant
        issue(32'h1003, 32'h0000_00A5, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        // LB / LBU with rvalid three cycles after grant
        issue(32'h2002, 0, 3'd0, 1, 0, 1, 1, 7, 0, 3, 32'h0080_0000);
        issue(32'h2002, 0, 3'd4, 1, 0, 1, 1, 8, 0, 3, 32'h0080_0000);
        // misaligned LH, then a plain op to show the error is a single pulse
        issue(32'h3001, 0, 3'd1, 1, 0, 1, 1, 9, 0, 1, 0);
        issue(32'h0042, 0, 3'd0, 0, 0, 1, 0, 4, 0, 0, 0);
        // SW with grant two cycles late
        issue(32'h4000, 32'h1234_5678, 3'd2, 0, 1, 0, 0, 0, 2, 0, 0);
        // ALU op then LW back to back
        issue(32'h1234, 0, 3'd0, 0, 0, 1, 0, 5, 0, 0, 0);
        issue(32'h5004, 0, 3'd2, 1, 0, 1, 1, 6, 1, 1, 32'hCAFE_F00D);
        // halfword paths and reserved encodings
        issue(32'h6002, 32'hAAAA_BEEF, 3'd1, 0, 1, 0, 0, 0, 0, 0, 0);
        issue(32'h7002, 0, 3'd1, 1, 0, 1, 1, 10, 0, 1, 32'h8001_7FFF);
        issue(32'h7002, 0, 3'd5, 1, 0, 1, 1, 11, 1, 2, 32'h8001_7FFF);
        issue(32'h7001, 0, 3'd4, 1, 0, 1, 1, 12, 0, 1, 32'h1122_3344);
        issue(32'h8000, 32'h55, 3'd4, 0, 1, 0, 0, 0, 0, 0, 0);
        issue(32'h8000, 0, 3'd6, 1, 0, 1, 1, 13, 0, 1, 0);

        // reset while waiting for rvalid, then a late rvalid
        alu_MEM = 32'h9000; funct3_MEM = 3'd2; MemRead_MEM = 1; RegWrite_MEM = 1;
        MemtoReg_MEM = 1; rd_MEM = 14; dmem.gnt = 1;
        @(posedge clk); #1;
        dmem.gnt = 0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_req", dmem.req, 0);
        check("rst_stall", stall_MEM, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_rw", RegWrite_WB, 0);
        check("rst_mid_ld", load_data_WB, 0);
        check("rst_mid_rd", rd_WB, 0);
        nop_ctrl();
        alu_MEM = 32'h77; RegWrite_MEM = 1; rd_MEM = 3;
        dmem.rvalid = 1; dmem.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("late_rv_req", dmem.req, 0);
        check("late_rv_stall", stall_MEM, 0);
        @(posedge clk); #1;
        dmem.rvalid = 0;
        check("late_rv_alu", alu_WB, 32'h77);
        check("late_rv_ld", load_data_WB, 0);
        check("late_rv_rd", rd_WB, 3);
        // FSM must be idle and accept a fresh load
        issue(32'hA008, 0, 3'd2, 1, 0, 1, 1, 15, 0, 1, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

MEM-stage load/store unit of the RV32I pipeline: sits on the consumer side of the EX/MEM pipeline register. Turns the registered `*_MEM` signals into data-memory bus transactions with a req/gnt/rvalid handshake, formats byte/half/word accesses, and stalls the pipeline while an access is outstanding. Produces the registered MEM/WB outputs consumed by the write-back stage.

## Interface
- No parameters; the data path is fixed at 32 bits.
- `clk`  in  1  sole clock; all state changes on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `alu_MEM`  in  32  effective address, or ALU result for pass-through
- `rs2_mem_data_MEM`  in  32  store data
- `funct3_MEM`  in  3  access size and sign (RV32I load/store encoding)
- `MemRead_MEM`, `MemWrite_MEM`, `RegWrite_MEM`, `MemtoReg_MEM`  in  1 each  control from EX/MEM
- `rd_MEM`  in  5  destination register
- `dmem_req`  out  1  access request
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  32  word address, `{alu_MEM[31:2],2'b00}`
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_gnt`  in  1  request accepted
- `dmem_rvalid`  in  1  load data valid
- `dmem_rdata`  in  32  load data word
- `stall_MEM`  out  1  freezes PC/IF/ID/EX/EX-MEM; upstream holds all `*_MEM` inputs stable while high
- `alu_WB`, `load_data_WB`  out  32 each  registered results
- `RegWrite_WB`, `MemtoReg_WB`  out  1 each  registered control
- `rd_WB`  out  5  registered destination
- `misalign_err_WB`  out  1  one-cycle pulse: access was suppressed

## Operation
- An access is pending when `MemRead_MEM | MemWrite_MEM`. It is illegal when it is misaligned (half with `addr[0]`=1; word with `addr[1:0]`≠0) or uses a reserved funct3 (loads 3/6/7, stores ≥3).
- Illegal accesses:
  - Never reach the bus and never stall.
  - WB gets a bubble with `misalign_err_WB`=1.
- Store lanes:
  - SB: `be`=`4'b0001<<addr[1:0]`, `wdata`=`{4{rs2[7:0]}}`.
  - SH: `be`=`4'b0011<<{addr[1],1'b0}`, `wdata`=`{2{rs2[15:0]}}`.
  - SW: `be`=`4'hF`, `wdata`=rs2.
- Loads: select byte/half at `addr[1:0]` from `dmem_rdata`; LB/LH sign-extend, LBU/LHU zero-extend. `dmem_be` is driven the same way as for stores.
- FSM states IDLE and RESP.
  - IDLE, legal access: `dmem_req`=1, Mealy on inputs.
    - Store: `stall_MEM`=`!dmem_gnt`. Completes in the gnt cycle.
    - Load: `stall_MEM`=1. On gnt → RESP.
  - RESP: `dmem_req`=0, `stall_MEM`=`!dmem_rvalid`. On rvalid, capture formatted data → IDLE.
  - `dmem_rvalid` is ignored in IDLE.
- WB register update at each edge:
  - `stall_MEM`=1: load a bubble (`RegWrite_WB`, `MemtoReg_WB`, `misalign_err_WB`=0; `rd_WB`=0; data regs 0).
  - Otherwise: capture `alu_MEM`, the formatted load data, the control signals and `rd_MEM`. For illegal accesses, `RegWrite_WB`=0 and `misalign_err_WB`=1.
  - `load_data_WB` is 0 for non-loads.

## Timing
- Reset (`rst_n`=0 at an edge): FSM → IDLE; every WB output = 0.
  - While `rst_n` is low, `dmem_req`=0 and `stall_MEM`=0 combinationally.
  - A reset mid-transaction abandons it. A late rvalid after reset is ignored.
- `dmem_req` holds, with addr/be/wdata/we stable, until the gnt cycle.
- The responder asserts rvalid ≥1 cycle after gnt.
- Latency:
  - Store with same-cycle gnt: 0 stall cycles.
  - Load: minimum 1 stall cycle (gnt at t, rvalid at t+1). Data is visible on `load_data_WB` at t+2.
- Only one outstanding access; no new request while in RESP.
- Non-memory instructions pass through with 1-cycle register latency and no stall.

## Structure
- Shared package `rv32_pkg`:
  - funct3 constants: F3_B/H/W/BU/HU.
  - FSM state encodings: S_IDLE, S_RESP.
- One combinational sub-module, `lsu_align`:
  - Inputs: funct3, `addr[1:0]`, rs2, rdata.
  - Outputs: be, wdata, extended load data, illegal flag.

## Test plan
- Reset: drive `rst_n`=0 during RESP, then a late rvalid → all WB outputs 0, FSM idle, `dmem_req`=0, no capture.
- SB: `alu`=0x1003, rs2=0xA5, gnt same cycle → addr 0x1000, be=4'b1000, wdata=0xA5A5A5A5, `stall_MEM` never high.
- LB: addr 0x2002, rdata=0x0080_0000, gnt at t, rvalid at t+3 → stall high t..t+2, `load_data_WB`=0xFFFFFF80. With funct3=LBU the result is 0x00000080.
- LH at 0x3001 → no `dmem_req`, no stall, `misalign_err_WB`=1 for one cycle, `RegWrite_WB`=0.
- Delayed gnt on SW (gnt after 2 cycles) → req and addr stable throughout, 2 bubble cycles into WB with `RegWrite_WB`=0.
- ALU op (RegWrite=1, rd=5, alu=0x1234) followed back-to-back by LW → first is passed through next cycle, LW stalls correctly, no dropped or duplicated WB entry.
